// File: rtl/serial_arith_pkg.sv
// Shared types and default widths for the serial arithmetic datapath
// (serial multiplier and serial divider share one controller).
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } arith_state_t;

  localparam int DIVIDEND_W_DEF = 32;
  localparam int DIVISOR_W_DEF  = 16;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift in a dividend bit, subtract
// the divisor when it fits, and report the resulting quotient bit.
module div_step #(
  parameter int DIVISOR_W = 16
) (
  input  logic [DIVISOR_W-1:0] r_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] r_o,
  output logic                 qbit_o
);

  logic [DIVISOR_W:0] sh;

  always_comb begin
    sh     = {r_i, bit_i};
    qbit_o = (sh >= {1'b0, divisor_i});
    // The true difference is below the divisor, so DIVISOR_W-bit wraparound is exact.
    r_o    = qbit_o ? (sh[DIVISOR_W-1:0] - divisor_i) : sh[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/serial_divider.sv
// Serial restoring divider, one quotient bit per clock, start/done handshake.
// Define SIGNED_DIV_EN for two's-complement truncating division.
module serial_divider
  import serial_arith_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  done,
  output logic                  busy
);

  localparam int CW = $clog2(DIVIDEND_W) + 1;

  arith_state_t          state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W-1:0]  r_q, r_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  zero_q, zero_d;
  logic                  dbz_q, dbz_d;

  logic                  div_zero;
  logic [DIVIDEND_W-1:0] a_mag;
  logic [DIVISOR_W-1:0]  b_mag;
  logic [DIVISOR_W-1:0]  r_nx;
  logic                  qbit;
  logic [DIVIDEND_W-1:0] q_raw;
  logic [DIVIDEND_W-1:0] q_fin;
  logic [DIVISOR_W-1:0]  r_fin;

  assign div_zero = (divisor == '0);

  div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .r_i      (r_q),
    .bit_i    (dvd_q[DIVIDEND_W-1]),
    .divisor_i(dsr_q),
    .r_o      (r_nx),
    .qbit_o   (qbit)
  );

  assign q_raw = {quo_q[DIVIDEND_W-2:0], qbit};

`ifdef SIGNED_DIV_EN
  logic nq_q, nq_d;
  logic nr_q, nr_d;
  logic a_neg, b_neg;

  assign a_neg = dividend[DIVIDEND_W-1];
  assign b_neg = divisor[DIVISOR_W-1];
  // Divide-by-zero keeps the raw dividend so it matches the unsigned result.
  assign a_mag = (a_neg && !div_zero) ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;
  assign nq_d  = (state_q == IDLE && start) ? ((a_neg ^ b_neg) && !div_zero) : nq_q;
  assign nr_d  = (state_q == IDLE && start) ? (a_neg && !div_zero) : nr_q;
  assign q_fin = nq_q ? -q_raw : q_raw;
  assign r_fin = nr_q ? -r_nx : r_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nq_q <= 1'b0;
      nr_q <= 1'b0;
    end else begin
      nq_q <= nq_d;
      nr_q <= nr_d;
    end
  end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fin = q_raw;
  assign r_fin = r_nx;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    r_d     = r_q;
    quo_d   = quo_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CW'(DIVIDEND_W);
          dvd_d   = a_mag;
          dsr_d   = b_mag;
          r_d     = '0;
          quo_d   = '0;
          zero_d  = div_zero;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
        r_d   = r_nx;
        quo_d = q_raw;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quot_d  = q_fin;
          rem_d   = r_fin;
          dbz_d   = zero_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign done        = (state_q == DONE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serial_divider.sv
// Scoreboard bench for serial_divider: directed vectors, queued
// expectations checked by a monitor on every done pulse.
module tb_serial_divider;

  localparam int NW = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        done;
  logic        busy;

  serial_divider dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        z;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_q"}, quotient, e.q);
        chk({e.name, "_r"}, {16'h0, remainder}, {16'h0, e.r});
        chk({e.name, "_dbz"}, {31'h0, div_by_zero}, {31'h0, e.z});
        chk({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [15:0] b,
                       input logic [31:0] q, input logic [15:0] r,
                       input logic z, input bit push, input string nm);
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) sb.push_back('{q, r, z, cyc + 1 + NW, nm});
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int c0;
    int low;
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    chk("rst_q", quotient, 32'h0);
    chk("rst_r", {16'h0, remainder}, 32'h0);
    chk("rst_dbz", {31'h0, div_by_zero}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    issue(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 1'b1, "div100_7");
`ifdef SIGNED_DIV_EN
    issue(32'hFFFFFFFF, 16'hFFFF, 32'h1, 16'h0, 1'b0, 1'b1, "neg1_neg1");
`else
    issue(32'hFFFFFFFF, 16'hFFFF, 32'h00010001, 16'h0, 1'b0, 1'b1, "max_max");
`endif

    issue(32'h12345678, 16'h0, 32'hFFFFFFFF, 16'h5678, 1'b1, 1'b1, "divzero");
    repeat (5) @(negedge clk);
    dividend = 32'd9;
    divisor  = 16'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;

`ifdef SIGNED_DIV_EN
    issue(32'hFFFFFF9C, 16'd7, 32'hFFFFFFF2, 16'hFFFE, 1'b0, 1'b1, "sneg100_7");
    issue(32'h80000000, 16'hFFFF, 32'h80000000, 16'h0, 1'b0, 1'b1, "smin_neg1");
`else
    issue(32'hFFFFFF9C, 16'd7, 32'h24924916, 16'd2, 1'b0, 1'b1, "u_big_7");
`endif

    wait_idle();
    c0       = cyc;
    dividend = 32'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    sb.push_back('{32'd14, 16'd2, 1'b0, c0 + 33, "held0"});
    sb.push_back('{32'd14, 16'd2, 1'b0, c0 + 67, "held1"});
    sb.push_back('{32'd14, 16'd2, 1'b0, c0 + 101, "held2"});
    low = 0;
    repeat (101) begin
      @(negedge clk);
      if (!busy) low++;
    end
    start = 1'b0;
    chk("held_idle_gaps", low, 32'd2);

    issue(32'hFFFFFFFF, 16'hFFFF, 32'h0, 16'h0, 1'b0, 1'b0, "abandoned");
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_q", quotient, 32'h0);
    chk("mid_rst_r", {16'h0, remainder}, 32'h0);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    issue(32'd9, 16'd3, 32'd3, 16'd0, 1'b0, 1'b1, "div9_3");

    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
    end
    repeat (40) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
